// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a hold-time limit.
// Drives a registered one-hot (or all-zero) grant vector, a busy flag that
// mirrors OR(grant), and a one-cycle timeout pulse after a forced release.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [3:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          found;
  logic [1:0]    sel;
  logic [1:0]    idx;
  logic          rel_done;
  logic          rel_drop;
  logic          rel_hold;

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    idx   = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Release causes; done outranks a request drop, which outranks the hold limit.
  always_comb begin
    rel_done = done;
    rel_drop = !req[owner_q];
    rel_hold = (hcnt_q == HOLD_LAST);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hcnt_d    = hcnt_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = sel;
          grant_d = 4'b0001 << sel;
          busy_d  = 1'b1;
          hcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = owner_q + 2'd1;
          state_d   = IDLE;
          timeout_d = !rel_done && !rel_drop;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hcnt_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hcnt_q    <= hcnt_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 (MAX_HOLD = 16).
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int errors;
  int checks;

  rr_arbiter4 #(.MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then stable for sampling and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_first_grant();
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got=%b exp=0001", grant); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got=%b exp=1", busy); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL first_timeout got=%b exp=0", timeout); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp = 4'b0001 << k;
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (grant !== exp || busy !== 1'b1)
          begin errors++; $display("FAIL fair_grant k=%0d c=%0d got=%b/%b exp=%b/1", k, c, grant, busy, exp); end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0)
        begin errors++; $display("FAIL fair_bubble k=%0d got=%b/%b exp=0000/0", k, grant, busy); end
    end
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL fair_wrap got=%b exp=0001", grant); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_g3 got=%b exp=1000", grant); end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_g0 got=%b exp=0001", grant); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_next got=%b exp=1000", grant); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    req = 4'b0100;
    tick();
    cnt = 0;
    while (grant === 4'b0100 && cnt < 40) begin
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL to_early cyc=%0d got=%b exp=0", cnt, timeout); end
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 16) begin errors++; $display("FAIL to_len got=%0d exp=16", cnt); end
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1)
      begin errors++; $display("FAIL to_pulse got=%b/%b exp=0000/1", grant, timeout); end
    tick();
    checks++;
    if (grant !== 4'b0100 || timeout !== 1'b0)
      begin errors++; $display("FAIL to_regrant got=%b/%b exp=0100/0", grant, timeout); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL drop_hold got=%b exp=0010", grant); end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0)
      begin errors++; $display("FAIL drop_rel got=%b/%b/%b exp=0000/0/0", grant, busy, timeout); end
    tick();
  endtask

  // done or a request drop on the final hold cycle: release without a timeout pulse.
  task automatic test_coincide();
    for (int m = 0; m < 2; m++) begin
      do_reset();
      req = 4'b0001;
      tick();
      for (int c = 0; c < 15; c++) tick();
      checks++;
      if (grant !== 4'b0001) begin errors++; $display("FAIL co_last m=%0d got=%b exp=0001", m, grant); end
      if (m == 0) done = 1'b1;
      else        req  = 4'b0000;
      tick();
      done = 1'b0;
      req  = 4'b0000;
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0)
        begin errors++; $display("FAIL co_rel m=%0d got=%b/%b exp=0000/0", m, grant, timeout); end
      tick();
    end
  endtask

  task automatic test_done_idle();
    do_reset();
    done = 1'b1;
    req  = 4'b0100;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL done_idle got=%b exp=0100", grant); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL rm_pre got=%b exp=1000", grant); end
    rst = 1'b1;
    req = 4'b1111;
    tick();
    rst = 1'b0;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0)
      begin errors++; $display("FAIL rm_clear got=%b/%b exp=0000/0", grant, busy); end
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL rm_ptr got=%b exp=0001", grant); end
    // Reset on the final hold cycle must suppress the timeout pulse.
    req = 4'b0001;
    for (int c = 0; c < 15; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0000;
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0)
      begin errors++; $display("FAIL rm_to got=%b/%b exp=0000/0", grant, timeout); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    test_reset();
    test_first_grant();
    test_fairness();
    test_wrap();
    test_timeout();
    test_drop();
    test_coincide();
    test_done_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that produces the one-hot grant vector consumed by the 4-to-2 encoder stage, which turns it into a 2-bit owner index. It holds each grant until the owner signals completion, drops its request, or exceeds a hold-time limit. It guarantees that at most one grant bit is set in every cycle, so the downstream encoder never sees an invalid input while a grant is active.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one grant may stay asserted. Legal range is 2 or more. The hold counter is $clog2(MAX_HOLD) bits wide.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit i belongs to requester i.
- done  input  1  release strobe from the current owner. Ignored while no grant is active.
- grant  output  4  registered grant vector: either 0000 or exactly one bit set.
- busy  output  1  registered; high whenever grant is non-zero.
- timeout  output  1  registered one-cycle pulse, high in the cycle after a forced release.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - 2-bit round-robin pointer ptr.
  - 2-bit owner register.
  - Hold counter hcnt.
- Reset: state IDLE, ptr 0, owner 0, hcnt 0, grant 0000, busy 0, timeout 0.
- IDLE:
  - If req is 0000, stay in IDLE with outputs unchanged (all zero).
  - Otherwise, select the first set request bit searching in the order ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Load owner with the selected index, set grant to the one-hot of owner, set busy to 1, clear hcnt, and move to GRANT.
- GRANT: a release condition is evaluated at each edge. Conditions in priority order:
  1. done is 1.
  2. req[owner] is 0.
  3. hcnt equals MAX_HOLD-1 (timeout).
- On release:
  - grant goes to 0000 and busy to 0.
  - ptr becomes owner+1 mod 4 (wrap from 3 to 0).
  - The FSM returns to IDLE.
  - timeout is set to 1 only if condition 3 caused the release.
- Without a release, hcnt increments and grant holds.
- timeout clears to 0 at every edge where it is not being set.
- Requests from non-owners during GRANT are ignored. No preemption.
- The pointer advances only on release, never in IDLE.

## Timing
- Request-to-grant latency is 1 cycle: a request sampled at edge N in IDLE gives grant valid after edge N.
- Release-to-clear latency is 1 cycle: a release condition sampled at edge N gives grant 0000 after edge N.
- There is one mandatory bubble cycle (grant 0000) between consecutive grants, even with requests pending. Back-to-back grant rate is therefore one grant per (hold+1) cycles.
- A grant is high for at most MAX_HOLD consecutive cycles. hcnt is 0 in the first grant cycle.
- done coinciding with a timeout release: done wins and timeout stays 0.
- req[owner] dropping in the same cycle as hcnt equals MAX_HOLD-1: the release counts as a request drop and timeout stays 0.
- done asserted in IDLE, or in the same cycle as the request that starts a grant, has no effect.
- rst asserted mid-grant: after that edge, grant is 0000, ptr is 0, and any pending timeout pulse is cancelled. rst takes priority over every other condition.
- Invariants:
  - grant is always 0000 or one-hot.
  - busy always equals OR of grant.

## Test plan
- Reset, then req=0001 held: grant=0001 and busy=1 exactly one cycle after req is sampled, with timeout=0.
- Fairness:
  - Stimulus: req=1111 held, done pulsed in the 3rd cycle of each grant.
  - Required grant sequence: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001, with each non-zero grant lasting 3 cycles.
- Wrap-around:
  - Stimulus: grant requester 3 and release with done (ptr becomes 0), then req=1001.
  - Required response: grant=0001.
  - Follow-up: after that release, requester 3 is granted next (grant=1000).
- Timeout with MAX_HOLD=16:
  - Stimulus: req=0100 held, done=0.
  - Required response: grant=0100 for exactly 16 cycles; then grant=0000 and timeout=1 for one cycle; then grant=0100 again (ptr=3, only requester 2 pending).
- Request drop and coincidences:
  - Owner 1 deasserts req mid-grant: grant clears after the next edge with timeout=0.
  - done and the timeout boundary in the same cycle: timeout=0.
- Reset mid-grant:
  - Stimulus: rst=1 for one cycle while grant=1000.
  - Required response: grant=0000 and busy=0 after that edge; with req=1111 afterwards, the first grant is 0001 (ptr reset to 0).
